gc_line_filter: RTL and testbench

Parametrised multi-channel debouncer for the GameCube controller data lines. It synchronises each raw line, requires THRESH consecutive agreeing samples before changing the filtered level, and reports level changes and rejected glitches as single-cycle pulses. It sits between the pad pins and the bit-decoding logic, replacing the single-channel fixed-count filter. It also adds reset, per-channel edge strobes and glitch reporting.

---
 rtl/gc_line_filter.sv | 112 +++++++++++
 tb/tb_gc_line_filter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/gc_line_filter.sv
// -----------------------------------------------------------------------------
// gc_line_filter
//   Multi-channel debouncer for the GameCube controller data lines. Each raw
//   line is synchronised, then a per-channel run counter must see THRESH
//   consecutive enabled samples that differ from the filtered level before
//   that level flips. Level changes are reported as one-cycle rise/fall
//   strobes; differing runs that end early are reported as a glitch strobe.
//
// Parameters
//   NUM_CH       number of independent channels
//   THRESH       consecutive differing samples needed to flip (1..2**CNT_W)
//   CNT_W        run-counter width
//   SYNC_STAGES  synchroniser depth per channel (>= 2)
//   INIT         reset level of synchronisers and filtered outputs
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_i        synchronous active-high reset
//   enable_i     filtering enable, shared by all channels
//   line_i       raw asynchronous lines
//   debounced_o  filtered level per channel (registered)
//   rise_o       one-cycle pulse on filtered 0->1
//   fall_o       one-cycle pulse on filtered 1->0
//   glitch_o     one-cycle pulse when a differing run ends short of THRESH
// -----------------------------------------------------------------------------
module gc_line_filter #(
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned THRESH      = 7,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        INIT        = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [NUM_CH-1:0] line_i,
  output logic [NUM_CH-1:0] debounced_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] glitch_o
);

  // Count value at which the next differing sample completes the run.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0]                  deb_q, deb_d;
  logic [NUM_CH-1:0]                  rise_q, rise_d;
  logic [NUM_CH-1:0]                  fall_q, fall_d;
  logic [NUM_CH-1:0]                  glitch_q, glitch_d;

  // Next-state: synchroniser shift and per-channel run/flip/glitch decision.
  always_comb begin
    sync_d   = sync_q;
    cnt_d    = cnt_q;
    deb_d    = deb_q;
    rise_d   = {NUM_CH{1'b0}};
    fall_d   = {NUM_CH{1'b0}};
    glitch_d = {NUM_CH{1'b0}};
    for (int i = 0; i < int'(NUM_CH); i++) begin
      // The chain keeps shifting while disabled so that re-enabling never
      // evaluates a stale sample.
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], line_i[i]};
      if (!enable_i) begin
        // Abandoning a run because of enable is not a glitch.
        cnt_d[i] = CNT_ZERO;
      end else if (sync_q[i][SYNC_STAGES-1] == deb_q[i]) begin
        if (cnt_q[i] != CNT_ZERO) begin
          cnt_d[i]    = CNT_ZERO;
          glitch_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i];
        end
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i]  = sync_q[i][SYNC_STAGES-1];
        cnt_d[i]  = CNT_ZERO;
        rise_d[i] = sync_q[i][SYNC_STAGES-1];
        fall_d[i] = ~sync_q[i][SYNC_STAGES-1];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // State and output registers with synchronous reset to INIT.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= {NUM_CH{{SYNC_STAGES{INIT}}}};
      cnt_q    <= {NUM_CH{CNT_ZERO}};
      deb_q    <= {NUM_CH{INIT}};
      rise_q   <= {NUM_CH{1'b0}};
      fall_q   <= {NUM_CH{1'b0}};
      glitch_q <= {NUM_CH{1'b0}};
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      deb_q    <= deb_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign debounced_o = deb_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  assign glitch_o    = glitch_q;

endmodule

// File: tb/tb_gc_line_filter.sv
// -----------------------------------------------------------------------------
// tb_gc_line_filter
//   Directed bench for gc_line_filter. Three instances share one clock:
//     u_a  defaults (1 channel, THRESH 7, 2 sync stages, INIT 0)
//     u_b  4 channels, INIT 1
//     u_c  THRESH 1, 3 sync stages
//   Inputs are driven on the falling edge; outputs are checked on the
//   falling edge after each rising edge. Index j counts rising edges, with
//   j = 0 being the first edge that samples the newly driven value.
// -----------------------------------------------------------------------------
module tb_gc_line_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A
  logic a_rst, a_en, a_line;
  logic a_deb, a_rise, a_fall, a_glitch;
  // Instances B and C share a reset
  logic bc_rst;
  logic b_en;
  logic [3:0] b_line, b_deb, b_rise, b_fall, b_glitch;
  logic c_en, c_line;
  logic c_deb, c_rise, c_fall, c_glitch;

  gc_line_filter u_a (
    .clk_i(clk), .rst_i(a_rst), .enable_i(a_en), .line_i(a_line),
    .debounced_o(a_deb), .rise_o(a_rise), .fall_o(a_fall), .glitch_o(a_glitch)
  );

  gc_line_filter #(.NUM_CH(4), .INIT(1'b1)) u_b (
    .clk_i(clk), .rst_i(bc_rst), .enable_i(b_en), .line_i(b_line),
    .debounced_o(b_deb), .rise_o(b_rise), .fall_o(b_fall), .glitch_o(b_glitch)
  );

  gc_line_filter #(.THRESH(1), .SYNC_STAGES(3)) u_c (
    .clk_i(clk), .rst_i(bc_rst), .enable_i(c_en), .line_i(c_line),
    .debounced_o(c_deb), .rise_o(c_rise), .fall_o(c_fall), .glitch_o(c_glitch)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one scenario on instance A and check every cycle.
  task automatic run_a(input string tag, input int n, input int hi_len,
                       input int off_from, input int off_len, input int rst_at,
                       input logic init_deb, input int flip_at, input int glitch_at);
    logic deb_e;
    for (int j = 0; j < n; j++) begin
      a_line = (j < hi_len);
      a_en   = !(j >= off_from && j < off_from + off_len);
      a_rst  = (j == rst_at);
      tick();
      deb_e = (flip_at >= 0 && j >= flip_at) ? ~init_deb : init_deb;
      check_eq($sformatf("%s deb j=%0d", tag, j), 32'(a_deb), 32'(deb_e));
      check_eq($sformatf("%s rise j=%0d", tag, j), 32'(a_rise), 32'(j == flip_at && !init_deb));
      check_eq($sformatf("%s fall j=%0d", tag, j), 32'(a_fall), 32'(j == flip_at && init_deb));
      check_eq($sformatf("%s glitch j=%0d", tag, j), 32'(a_glitch), 32'(j == glitch_at));
    end
    a_en  = 1'b1;
    a_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] pat;
    logic [21:0] hist;
    logic        deb_e, prev_e;

    a_rst  = 1'b1; a_en = 1'b1; a_line = 1'b0;
    bc_rst = 1'b1; b_en = 1'b1; b_line = 4'hF;
    c_en   = 1'b1; c_line = 1'b0;
    @(negedge clk);
    tick();
    tick();

    // Reset state
    check_eq("rst a_deb", 32'(a_deb), 32'd0);
    check_eq("rst a_rise", 32'(a_rise), 32'd0);
    check_eq("rst a_fall", 32'(a_fall), 32'd0);
    check_eq("rst a_glitch", 32'(a_glitch), 32'd0);
    check_eq("rst b_deb", 32'(b_deb), 32'hF);
    check_eq("rst b_pulses", 32'(b_rise | b_fall | b_glitch), 32'd0);
    check_eq("rst c_deb", 32'(c_deb), 32'd0);
    a_rst  = 1'b0;
    bc_rst = 1'b0;
    tick();

    // Steady high: flips on edge 8, pulses once
    run_a("rise", 12, 12, -1, 0, -1, 1'b0, 8, -1);
    // Steady low back again
    run_a("fall", 12, 0, -1, 0, -1, 1'b1, 8, -1);
    // 4-sample pulse: rejected, glitch 6 edges after first high sample
    run_a("glitch", 12, 4, -1, 0, -1, 1'b0, -1, 6);
    // 5-sample run, enable low for 3 edges, then full 7 samples needed
    run_a("enable", 20, 20, 7, 3, -1, 1'b0, 16, -1);
    run_a("fall2", 12, 0, -1, 0, -1, 1'b1, 8, -1);
    // Reset on the 6th counted sample; counting restarts after release
    run_a("rstmid", 20, 20, -1, 0, 7, 1'b0, 16, -1);

    // Multi-channel, INIT 1: first bring channel 0 low
    for (int j = 0; j < 12; j++) begin
      b_line = 4'b1110;
      tick();
      check_eq($sformatf("b0 deb j=%0d", j), 32'(b_deb), (j >= 8) ? 32'hE : 32'hF);
      check_eq($sformatf("b0 fall j=%0d", j), 32'(b_fall), (j == 8) ? 32'h1 : 32'h0);
      check_eq($sformatf("b0 rise j=%0d", j), 32'(b_rise), 32'h0);
      check_eq($sformatf("b0 glitch j=%0d", j), 32'(b_glitch), 32'h0);
    end
    // Ch0 rises and ch3 falls together; ch1 dips for 3 samples; ch2 idle
    for (int j = 0; j < 12; j++) begin
      b_line = {1'b0, 1'b1, (j < 3) ? 1'b0 : 1'b1, 1'b1};
      tick();
      check_eq($sformatf("b1 deb j=%0d", j), 32'(b_deb), (j >= 8) ? 32'h7 : 32'hE);
      check_eq($sformatf("b1 rise j=%0d", j), 32'(b_rise), (j == 8) ? 32'h1 : 32'h0);
      check_eq($sformatf("b1 fall j=%0d", j), 32'(b_fall), (j == 8) ? 32'h8 : 32'h0);
      check_eq($sformatf("b1 glitch j=%0d", j), 32'(b_glitch), (j == 5) ? 32'h2 : 32'h0);
    end

    // THRESH 1, 3 sync stages: output is the line delayed by 3 edges
    pat  = 16'b0110_1011_0010_1101;
    hist = 22'd0;
    for (int j = 0; j < 22; j++) begin
      c_line  = (j < 16) ? pat[j] : 1'b0;
      hist[j] = c_line;
      tick();
      deb_e  = (j >= 3) ? hist[j-3] : 1'b0;
      prev_e = (j >= 4) ? hist[j-4] : 1'b0;
      check_eq($sformatf("c deb j=%0d", j), 32'(c_deb), 32'(deb_e));
      check_eq($sformatf("c rise j=%0d", j), 32'(c_rise), 32'(deb_e & ~prev_e));
      check_eq($sformatf("c fall j=%0d", j), 32'(c_fall), 32'(~deb_e & prev_e));
      check_eq($sformatf("c glitch j=%0d", j), 32'(c_glitch), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
